// File: rtl/synth_gate_sequencer.sv
// Command sequencer between the SPI word register and the synth voice.
// Qualifies a new word, decodes it as a note command and times gate/amplitude.
module synth_gate_sequencer #(
    parameter int STABLE_CYCLES = 16,
    parameter int RETRIG_GAP    = 480,
    parameter int MAX_GATE      = 0,
    parameter int TIMER_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    output logic        gate,
    output logic [9:0]  amp_out,
    output logic [1:0]  state_out,
    output logic [7:0]  cmd_count,
    output logic        err_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(STABLE_CYCLES);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(RETRIG_GAP - 1);
    localparam logic [TIMER_W-1:0] GATE_LAST = TIMER_W'((MAX_GATE > 0) ? (MAX_GATE - 1) : 0);

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_NOTE_ON  = 4'd1;
    localparam logic [3:0] OP_NOTE_OFF = 4'd2;
    localparam logic [3:0] OP_SET_AMP  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          cand, cand_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [15:0]          last_word, last_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 gate_nxt;
    logic [9:0]           amp_nxt;
    logic [7:0]           cmd_nxt;
    logic                 err_nxt;
    logic                 accept;
    logic [3:0]           opcode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_FULL) ? c : c + CNT_W'(1);
    endfunction

    assign opcode    = word_in[15:12];
    assign state_out = state;

    // Qualification: the word seen this edge becomes the candidate, so acceptance
    // decisions use word_in directly and land on the STABLE_CYCLES-th edge.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (word_in != cand) begin
            cand_nxt = word_in;
            cnt_nxt  = CNT_W'(1);
        end else begin
            cnt_nxt = sat_inc(cnt);
        end
        accept = (cnt_nxt == CNT_FULL) && (word_in != last_word);
    end

    always_comb begin
        state_nxt = state;
        gate_nxt  = gate;
        amp_nxt   = amp_out;
        timer_nxt = timer;
        cmd_nxt   = cmd_count;
        err_nxt   = 1'b0;
        last_nxt  = last_word;
        if (accept) begin
            // An accepted word freezes the timer for this edge, so it also
            // overrides any gap expiry or timeout due on the same edge.
            last_nxt = word_in;
            case (opcode)
                OP_NOP: begin
                end
                OP_NOTE_ON: begin
                    amp_nxt   = word_in[9:0];
                    cmd_nxt   = cmd_count + 8'd1;
                    timer_nxt = '0;
                    if (state == ST_IDLE) begin
                        state_nxt = ST_ON;
                        gate_nxt  = 1'b1;
                    end else if (state == ST_ON) begin
                        state_nxt = ST_GAP;
                        gate_nxt  = 1'b0;
                    end
                end
                OP_NOTE_OFF: begin
                    cmd_nxt   = cmd_count + 8'd1;
                    state_nxt = ST_IDLE;
                    gate_nxt  = 1'b0;
                    timer_nxt = '0;
                end
                OP_SET_AMP: begin
                    amp_nxt = word_in[9:0];
                    cmd_nxt = cmd_count + 8'd1;
                end
                default: begin
                    err_nxt = 1'b1;
                end
            endcase
        end else begin
            case (state)
                ST_GAP: begin
                    if (timer == GAP_LAST) begin
                        state_nxt = ST_ON;
                        gate_nxt  = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TIMER_W'(1);
                    end
                end
                ST_ON: begin
                    if (MAX_GATE > 0) begin
                        if (timer == GATE_LAST) begin
                            state_nxt = ST_IDLE;
                            gate_nxt  = 1'b0;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TIMER_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    timer_nxt = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    gate_nxt  = 1'b0;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gate      <= 1'b0;
            amp_out   <= '0;
            cmd_count <= '0;
            err_pulse <= 1'b0;
            last_word <= '0;
            cand      <= '0;
            cnt       <= '0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            gate      <= gate_nxt;
            amp_out   <= amp_nxt;
            cmd_count <= cmd_nxt;
            err_pulse <= err_nxt;
            last_word <= last_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            timer     <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_synth_gate_sequencer.sv
// Bench for synth_gate_sequencer: two instances (no timeout / MAX_GATE=10)
// compared every cycle against a rule-level reference model.
module tb_synth_gate_sequencer;

    localparam int SC = 4;
    localparam int RG = 8;
    localparam int MGB = 10;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_in;
    logic        ga, gb, ea, eb;
    logic [9:0]  aa, ab;
    logic [1:0]  sa, sb;
    logic [7:0]  ca, cb;

    int total = 0;
    int bad = 0;

    int m_cand[2], m_cnt[2], m_last[2], m_st[2], m_gate[2];
    int m_amp[2], m_tm[2], m_cmd[2], m_err[2];

    synth_gate_sequencer #(.STABLE_CYCLES(SC), .RETRIG_GAP(RG), .MAX_GATE(0), .TIMER_W(16)) ua (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .gate(ga), .amp_out(aa),
        .state_out(sa), .cmd_count(ca), .err_pulse(ea));

    synth_gate_sequencer #(.STABLE_CYCLES(SC), .RETRIG_GAP(RG), .MAX_GATE(MGB), .TIMER_W(16)) ub (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .gate(gb), .amp_out(ab),
        .state_out(sb), .cmd_count(cb), .err_pulse(eb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_cand[i] = 0; m_cnt[i] = 0; m_last[i] = 0; m_st[i] = 0; m_gate[i] = 0;
        m_amp[i] = 0;  m_tm[i] = 0;  m_cmd[i] = 0;  m_err[i] = 0;
    endtask

    // One clock edge of the command rules for instance i (mg = max gate length).
    task automatic model_step(input int i, input int w, input int mg);
        bit acc;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        m_err[i] = 0;
        acc = 0;
        if (w != m_cand[i]) begin
            m_cand[i] = w;
            m_cnt[i] = 1;
        end else if (m_cnt[i] < SC) begin
            m_cnt[i]++;
        end
        if (m_cnt[i] == SC && m_cand[i] != m_last[i]) begin
            acc = 1;
            m_last[i] = m_cand[i];
        end
        if (acc) begin
            case (w >> 12)
                0: ;
                1: begin
                    m_amp[i] = w % 1024;
                    m_cmd[i] = (m_cmd[i] + 1) % 256;
                    m_tm[i] = 0;
                    if (m_st[i] == 0) begin m_st[i] = 1; m_gate[i] = 1; end
                    else if (m_st[i] == 1) begin m_st[i] = 2; m_gate[i] = 0; end
                end
                2: begin
                    m_cmd[i] = (m_cmd[i] + 1) % 256;
                    m_st[i] = 0; m_gate[i] = 0; m_tm[i] = 0;
                end
                3: begin
                    m_amp[i] = w % 1024;
                    m_cmd[i] = (m_cmd[i] + 1) % 256;
                end
                default: m_err[i] = 1;
            endcase
        end else if (m_st[i] == 2) begin
            if (m_tm[i] == RG - 1) begin m_st[i] = 1; m_gate[i] = 1; m_tm[i] = 0; end
            else m_tm[i]++;
        end else if (m_st[i] == 1 && mg > 0) begin
            if (m_tm[i] == mg - 1) begin m_st[i] = 0; m_gate[i] = 0; m_tm[i] = 0; end
            else m_tm[i]++;
        end else if (m_st[i] == 0) begin
            m_tm[i] = 0;
        end
    endtask

    task automatic compare_all();
        chk("a.gate", ga, m_gate[0]);
        chk("a.amp", aa, m_amp[0]);
        chk("a.state", sa, m_st[0]);
        chk("a.cmd", ca, m_cmd[0]);
        chk("a.err", ea, m_err[0]);
        chk("b.gate", gb, m_gate[1]);
        chk("b.amp", ab, m_amp[1]);
        chk("b.state", sb, m_st[1]);
        chk("b.cmd", cb, m_cmd[1]);
        chk("b.err", eb, m_err[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, int'(word_in), 0);
        model_step(1, int'(word_in), MGB);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n;
        int saved;
        rst_n = 1'b0;
        word_in = 16'h0000;
        model_reset(0);
        model_reset(1);
        ticks(2);
        chk("rst.gate", ga, 0);
        chk("rst.amp", aa, 0);
        chk("rst.state", sa, 0);
        chk("rst.cmd", ca, 0);
        #2 rst_n = 1'b1;
        tick();

        // Held NOTE_ON: acted on at the 4th edge, not the 3rd
        word_in = 16'h13FF;
        ticks(3);
        chk("t1.gate_e3", ga, 0);
        tick();
        chk("t1.gate", ga, 1);
        chk("t1.amp", aa, 1023);
        chk("t1.state", sa, 1);
        chk("t1.cmd", ca, 1);

        // Bouncing word is never accepted; acceptance 4 edges into the hold
        for (int k = 0; k < 10; k++) begin
            word_in = k[0] ? 16'h1200 : 16'h1100;
            ticks(2);
        end
        chk("t2.amp_toggle", aa, 1023);
        word_in = 16'h1100;
        ticks(3);
        chk("t2.amp_e3", aa, 1023);
        tick();
        chk("t2.amp", aa, 256);
        chk("t2.state", sa, 2);
        ticks(7);
        chk("t2.gap_state", sa, 2);
        tick();
        chk("t2.reon", sa, 1);

        // NOP then retrigger: gate low for exactly RETRIG_GAP cycles
        word_in = 16'h0000;
        ticks(SC);
        word_in = 16'h1200;
        ticks(SC);
        chk("t3.amp", aa, 512);
        chk("t3.state", sa, 2);
        n = 0;
        while (ga == 1'b0 && n < 50) begin tick(); n++; end
        chk("t3.gap_len", n, RG);

        // Timeout instance: gate high exactly MAX_GATE cycles
        word_in = 16'h2000;
        ticks(SC);
        word_in = 16'h1155;
        ticks(SC);
        chk("t4.b_gate", gb, 1);
        n = 0;
        while (gb == 1'b1 && n < 50) begin tick(); n++; end
        chk("t4.gate_len", n, MGB);
        chk("t4.b_state", sb, 0);

        // SET_AMP during ON
        saved = int'(ca);
        word_in = 16'h3055;
        ticks(SC);
        chk("t4.amp", aa, 85);
        chk("t4.gate", ga, 1);
        chk("t4.cmd", ca, (saved + 1) % 256);

        // Illegal opcode pulses err for one cycle only
        saved = int'(ca);
        word_in = 16'hF000;
        ticks(SC);
        chk("t5.err", ea, 1);
        chk("t5.cmd", ca, saved);
        tick();
        chk("t5.err_clr", ea, 0);
        for (int k = 0; k < 256; k++) begin
            word_in = k[0] ? 16'h3001 : 16'h3002;
            ticks(SC);
        end
        chk("t5.wrap", ca, saved);
        chk("t5.amp", aa, 1);

        // Async reset mid-gap, then the still-present word is re-accepted
        word_in = 16'h1300;
        ticks(SC);
        chk("t6.gap", sa, 2);
        ticks(3);
        #3 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("t6.gate", ga, 0);
        chk("t6.amp", aa, 0);
        chk("t6.state", sa, 0);
        compare_all();
        ticks(2);
        #2 rst_n = 1'b1;
        ticks(SC - 1);
        chk("t6.gate_e3", ga, 0);
        tick();
        chk("t6.reaccept", ga, 1);
        chk("t6.amp_re", aa, 768);
        chk("t6.state_re", sa, 1);

        // Randomized commands with random hold lengths
        for (int s = 0; s < 400; s++) begin
            int r;
            int op;
            r = $urandom_range(0, 9);
            if (r < 2)      op = 0;
            else if (r < 5) op = 1;
            else if (r < 7) op = 2;
            else if (r < 9) op = 3;
            else            op = $urandom_range(4, 15);
            word_in = {op[3:0], 12'($urandom)};
            ticks($urandom_range(1, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
